// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared definitions for the 0..9999 FND counter slice: FSM state codes
//   and the counter width/limit used by the counter and the FND wrapper.
package counter_ctrl_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned COUNT_W   = 14;
    localparam int unsigned COUNT_MAX = 9999;

    // 2'd3 is not a legal state; the FSM recovers from it to ST_STOP.
    typedef enum logic [STATE_W-1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
//   2-FF synchronizer plus stability filter for one raw push button.
//   Ports:
//     i_clk    system clock
//     i_reset  synchronous, active-high reset
//     i_btn    raw button level, asynchronous to i_clk
//     o_level  accepted (debounced) level
//     o_press  one-cycle pulse when the accepted level rises 0->1
module button_debouncer #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only advances while the synchronized level disagrees with
    // the accepted one; the DB_CYCLES-th disagreeing cycle flips the level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/counter_control_unit.sv
// counter_control_unit
//   Run/stop/clear sequencer for the 0..9999 FND up/down counter. Debounces
//   three buttons, runs a STOP/RUN/CLEAR FSM and issues single-cycle strobes
//   to a counter that lives on i_clk.
//   Ports:
//     i_clk         system clock
//     i_reset       synchronous, active-high reset
//     i_btnRunStop  raw run/stop button
//     i_btnClear    raw clear button
//     i_btnMode     raw direction-toggle button
//     o_tick        one-cycle count-enable strobe
//     o_clear       one-cycle synchronous clear strobe
//     o_dir         count direction, 1 = up
//     o_run         high while in RUN
//     o_state       current FSM state code
module counter_control_unit
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned TICK_DIV  = 10_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_btnRunStop,
    input  logic               i_btnClear,
    input  logic               i_btnMode,
    output logic               o_tick,
    output logic               o_clear,
    output logic               o_dir,
    output logic               o_run,
    output logic [STATE_W-1:0] o_state
);

    localparam int unsigned        PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic rs_press, clr_press, mode_press;
    logic rs_level, clr_level, mode_level;
    logic levels_unused;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;
    logic               clear_q, clear_d;
    logic               dir_q, dir_d;
    logic               run_q, run_d;

    button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_runstop (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btnRunStop),
        .o_level (rs_level),
        .o_press (rs_press)
    );

    button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btnClear),
        .o_level (clr_level),
        .o_press (clr_press)
    );

    button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btnMode),
        .o_level (mode_level),
        .o_press (mode_press)
    );

    // Only press pulses drive this block; the levels are kept for visibility.
    assign levels_unused = rs_level & clr_level & mode_level;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (clr_press) begin
                    state_d = ST_CLEAR;
                end else if (rs_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rs_press) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase

        // Prescaler and tick both look at the next state so that leaving RUN
        // drops a tick that would otherwise land in the first STOP cycle.
        presc_d = '0;
        tick_d  = 1'b0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            tick_d  = (presc_q == PRESC_LAST);
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end

        clear_d = (state_d == ST_CLEAR);
        run_d   = (state_d == ST_RUN);
        dir_d   = dir_q ^ mode_press;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            dir_q   <= 1'b1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
            dir_q   <= dir_d;
            run_q   <= run_d;
        end
    end

    assign o_tick  = tick_q;
    assign o_clear = clear_q;
    assign o_dir   = dir_q;
    assign o_run   = run_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_counter_control_unit.sv
// tb_counter_control_unit
//   Scenario tasks with fixed expectations plus a randomized run checked
//   against a cycle model built from the button/FSM/tick rules.
module tb_counter_control_unit;

    localparam int unsigned DB = 4;
    localparam int unsigned TD = 5;

    logic       clk;
    logic       rst;
    logic       btn_rs, btn_clr, btn_mode;
    logic       o_tick, o_clear, o_dir, o_run;
    logic [1:0] o_state;

    int tests;
    int fails;

    counter_control_unit #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_btnRunStop (btn_rs),
        .i_btnClear   (btn_clr),
        .i_btnMode    (btn_mode),
        .o_tick       (o_tick),
        .o_clear      (o_clear),
        .o_dir        (o_dir),
        .o_run        (o_run),
        .o_state      (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // bit 0 = run/stop, bit 1 = clear, bit 2 = mode
    bit [2:0]    m_s1, m_s2, m_lvl, m_press;
    int unsigned m_len [3];
    int unsigned m_state;
    int unsigned m_age;
    bit          m_tick, m_clear, m_dir;

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit [2:0]    raw;
        bit [2:0]    prs;
        int unsigned nxt;
        raw = {btn_mode, btn_clr, btn_rs};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
            for (int i = 0; i < 3; i++) m_len[i] = 0;
            m_state = 0; m_age = 0; m_tick = 0; m_clear = 0; m_dir = 1;
        end else begin
            prs = m_press;
            for (int i = 0; i < 3; i++) begin
                m_press[i] = 1'b0;
                if (m_s2[i] == m_lvl[i]) begin
                    m_len[i] = 0;
                end else begin
                    m_len[i] = m_len[i] + 1;
                    if (m_len[i] == DB) begin
                        m_lvl[i]   = m_s2[i];
                        m_len[i]   = 0;
                        m_press[i] = m_s2[i];
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            if (m_state == 0)      nxt = prs[1] ? 2 : (prs[0] ? 1 : 0);
            else if (m_state == 1) nxt = prs[0] ? 0 : 1;
            else                   nxt = 0;
            if (m_state == 1 && nxt == 1) begin
                m_age  = m_age + 1;
                m_tick = (m_age % TD) == 0;
            end else begin
                m_age  = 0;
                m_tick = 0;
            end
            m_clear = (nxt == 2);
            m_dir   = m_dir ^ prs[2];
            m_state = nxt;
        end
    endtask

    // All input changes happen before this call, so the model sees the
    // same values the DUT samples on the next edge.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic press_button(input int idx, input int hold, input int gap);
        if (idx == 0) btn_rs = 1'b1; else if (idx == 1) btn_clr = 1'b1; else btn_mode = 1'b1;
        cyc(hold);
        if (idx == 0) btn_rs = 1'b0; else if (idx == 1) btn_clr = 1'b0; else btn_mode = 1'b0;
        cyc(gap);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1; btn_rs = 1'b0; btn_clr = 1'b0; btn_mode = 1'b0;
        cyc(3);
        obs = {o_state, o_run, o_tick, o_clear, o_dir};
        tests++;
        if (obs !== 6'b00_0001) begin
            fails++;
            $display("FAIL reset_hold: got %b expected %b", obs, 6'b00_0001);
        end
        rst = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            cyc(1);
            obs = {o_state, o_run, o_tick, o_clear, o_dir};
            tests++;
            if (obs !== 6'b00_0001) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", j, obs, 6'b00_0001);
            end
        end
    endtask

    task automatic test_run_ticks();
        logic exp_tick;
        btn_rs = 1'b1;
        for (int j = 1; j <= 22; j++) begin
            cyc(1);
            exp_tick = (j == 12) || (j == 17) || (j == 22);
            tests++;
            if (o_run !== (j >= 7) || o_tick !== exp_tick) begin
                fails++;
                $display("FAIL run_ticks cyc %0d: got run=%b tick=%b expected run=%b tick=%b",
                         j, o_run, o_tick, (j >= 7), exp_tick);
            end
            if (j == 10) btn_rs = 1'b0;
        end
        btn_rs = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            tests++;
            if (o_run !== (j < 7) || (j >= 7 && o_tick !== 1'b0)) begin
                fails++;
                $display("FAIL run_stop cyc %0d: got run=%b tick=%b expected run=%b",
                         j, o_run, o_tick, (j < 7));
            end
            if (j == 8) btn_rs = 1'b0;
        end
    endtask

    task automatic test_bounce();
        for (int j = 0; j < 32; j++) begin
            btn_rs = (j < 24) ? (((j / 2) % 2) == 0) : 1'b0;
            cyc(1);
            tests++;
            if (o_state !== 2'd0 || o_run !== 1'b0 || o_tick !== 1'b0) begin
                fails++;
                $display("FAIL bounce cyc %0d: got state=%0d run=%b tick=%b expected state=0 run=0 tick=0",
                         j, o_state, o_run, o_tick);
            end
        end
    endtask

    task automatic test_clear_in_run();
        press_button(0, 8, 8);
        tests++;
        if (o_run !== 1'b1) begin
            fails++;
            $display("FAIL clr_run_enter: got run=%b expected 1", o_run);
        end
        btn_clr = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            tests++;
            if (o_state !== 2'd1 || o_clear !== 1'b0) begin
                fails++;
                $display("FAIL clr_ignored cyc %0d: got state=%0d clear=%b expected state=1 clear=0",
                         j, o_state, o_clear);
            end
            if (j == 8) btn_clr = 1'b0;
        end
        btn_rs = 1'b1;
        for (int j = 1; j <= 26; j++) begin
            cyc(1);
            tests++;
            if (o_run !== (j < 7) || (j >= 7 && o_tick !== 1'b0)) begin
                fails++;
                $display("FAIL clr_stop cyc %0d: got run=%b tick=%b expected run=%b",
                         j, o_run, o_tick, (j < 7));
            end
            if (j == 8) btn_rs = 1'b0;
        end
        btn_clr = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            tests++;
            if (o_state !== ((j == 7) ? 2'd2 : 2'd0) || o_clear !== (j == 7)) begin
                fails++;
                $display("FAIL clr_pulse cyc %0d: got state=%0d clear=%b expected state=%0d clear=%b",
                         j, o_state, o_clear, (j == 7) ? 2 : 0, (j == 7));
            end
            if (j == 8) btn_clr = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        btn_rs  = 1'b1;
        btn_clr = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc(1);
            tests++;
            if (o_run !== 1'b0 || o_state !== ((j == 7) ? 2'd2 : 2'd0) || o_clear !== (j == 7)) begin
                fails++;
                $display("FAIL simultaneous cyc %0d: got state=%0d run=%b clear=%b expected state=%0d run=0 clear=%b",
                         j, o_state, o_run, o_clear, (j == 7) ? 2 : 0, (j == 7));
            end
            if (j == 8) begin
                btn_rs  = 1'b0;
                btn_clr = 1'b0;
            end
        end
    endtask

    task automatic test_mode_reset();
        logic [5:0] obs;
        logic       exp_tick;
        logic       exp_dir;
        btn_rs = 1'b1;
        for (int j = 1; j <= 31; j++) begin
            cyc(1);
            if (j >= 7 && j <= 29) begin
                exp_tick = (j >= 12) && (((j - 12) % 5) == 0);
                exp_dir  = (j >= 20) ? 1'b0 : 1'b1;
                tests++;
                if (o_run !== 1'b1 || o_tick !== exp_tick || o_dir !== exp_dir) begin
                    fails++;
                    $display("FAIL mode_run cyc %0d: got run=%b tick=%b dir=%b expected run=1 tick=%b dir=%b",
                             j, o_run, o_tick, o_dir, exp_tick, exp_dir);
                end
            end else if (j >= 30) begin
                obs = {o_state, o_run, o_tick, o_clear, o_dir};
                tests++;
                if (obs !== 6'b00_0001) begin
                    fails++;
                    $display("FAIL mid_reset cyc %0d: got %b expected %b", j, obs, 6'b00_0001);
                end
            end
            if (j == 8)  btn_rs   = 1'b0;
            if (j == 13) btn_mode = 1'b1;
            if (j == 21) btn_mode = 1'b0;
            if (j == 29) rst      = 1'b1;
            if (j == 31) rst      = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [5:0]  obs, exp;
        int unsigned hold [3];
        for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 14);
        for (int c = 0; c < 1500; c++) begin
            cyc(1);
            obs = {o_state, o_run, o_tick, o_clear, o_dir};
            exp = {m_state[1:0], (m_state == 1), m_tick, m_clear, m_dir};
            tests++;
            if (obs !== exp || (o_tick && o_clear)) begin
                fails++;
                $display("FAIL random cyc %0d: got %b expected %b", c, obs, exp);
            end
            for (int i = 0; i < 3; i++) begin
                hold[i] = hold[i] - 1;
                if (hold[i] == 0) begin
                    hold[i] = $urandom_range(1, 14);
                    if (i == 0) btn_rs = ~btn_rs;
                    else if (i == 1) btn_clr = ~btn_clr;
                    else btn_mode = ~btn_mode;
                end
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_run_ticks();
        test_bounce();
        test_clear_in_run();
        test_simultaneous();
        test_mode_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
